// File: rtl/input_cond_pkg.sv
// Package: input_cond_pkg
// Purpose: types shared by the input conditioner and its per-channel debouncer.
//   deb_state_t : debounce FSM state. ST_LOW and ST_HIGH are the stable
//                 states. ST_WAIT_HIGH and ST_WAIT_LOW are the states that
//                 count a pending level change.
package input_cond_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// Module: debounce_channel
// Purpose: conditions one raw push-button/switch input in four stages:
//   1. 2-FF synchronizer.
//   2. Counter-based debounce FSM.
//   3. Registered rise and fall edge pulses.
//   4. A toggle flop that flips on every accepted rising edge.
// Ports:
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  synchronous active-low reset
//   raw    in  1  asynchronous raw input
//   level  out 1  debounced level
//   rise   out 1  one-cycle pulse on an accepted 0->1 change
//   fall   out 1  one-cycle pulse on an accepted 1->0 change
//   toggle out 1  flips together with rise
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  deb_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             toggle_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      state_reg  <= ST_LOW;
      cnt_reg    <= '0;
      level_reg  <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      toggle_reg <= 1'b0;
    end else begin
      // Only s2 is used downstream. Nothing sits between the two flops.
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      // A pulse lasts one cycle unless a commit below re-asserts it.
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;

      unique case (state_reg)
        ST_LOW: begin
          cnt_reg <= '0;
          if (s2_reg) state_reg <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (!s2_reg) begin
            // The excursion was too short: drop it and keep the old level.
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= ST_HIGH;
            cnt_reg    <= '0;
            level_reg  <= 1'b1;
            rise_reg   <= 1'b1;
            toggle_reg <= ~toggle_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HIGH: begin
          cnt_reg <= '0;
          if (!s2_reg) state_reg <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (s2_reg) begin
            state_reg <= ST_HIGH;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            fall_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_LOW;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign level  = level_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;
  assign toggle = toggle_reg;

endmodule

// File: rtl/input_conditioner.sv
// Module: input_conditioner
// Purpose: front end that turns raw, asynchronous buttons and switches into
//   clean, synchronous signals, using one independent debounce_channel per
//   input. At the datapath level the outputs are used as follows:
//     a   = btn_level[0]
//     b   = btn_level[1]
//     sel = btn_toggle[2]
// Ports:
//   clk        in  1     system clock
//   rst_n      in  1     synchronous active-low reset
//   btn_raw    in  N_IN  raw inputs
//   btn_level  out N_IN  debounced levels
//   btn_rise   out N_IN  one-cycle pulses on 0->1
//   btn_fall   out N_IN  one-cycle pulses on 1->0
//   btn_toggle out N_IN  latched selectors, flip on each rise
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_IN            = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] btn_raw,
  output logic [N_IN-1:0] btn_level,
  output logic [N_IN-1:0] btn_rise,
  output logic [N_IN-1:0] btn_fall,
  output logic [N_IN-1:0] btn_toggle
);

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw[gi]),
        .level (btn_level[gi]),
        .rise  (btn_rise[gi]),
        .fall  (btn_fall[gi]),
        .toggle(btn_toggle[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn_raw;
  logic [2:0] btn_level, btn_rise, btn_fall, btn_toggle;

  int checks = 0;
  int errors = 0;
  int rise_cnt [3];
  int fall_cnt [3];

  input_conditioner #(.N_IN(3), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_toggle(btn_toggle)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and sample 1 time unit after each edge. Each sample
  // also updates the per-channel pulse counters.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (btn_rise[c]) rise_cnt[c]++;
        if (btn_fall[c]) fall_cnt[c]++;
      end
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 3; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s got=%0h exp=%0h", tag, obs, exp);
  endtask

  initial begin
    clear_counts();

    // 1. Reset held with all inputs high, then released.
    rst_n = 1'b0; btn_raw = 3'b111;
    tick(3);
    check("rst_level",  btn_level,  3'b000);
    check("rst_rise",   btn_rise,   3'b000);
    check("rst_fall",   btn_fall,   3'b000);
    check("rst_toggle", btn_toggle, 3'b000);
    rst_n = 1'b1;
    tick(6);                       // edges 0..5 after release
    check("t1_level_e5", btn_level, 3'b000);
    tick(1);                       // edge 6
    check("t1_level_e6",  btn_level,  3'b111);
    check("t1_rise_e6",   btn_rise,   3'b111);
    check("t1_toggle_e6", btn_toggle, 3'b111);
    tick(1);
    check("t1_rise_e7",  btn_rise,  3'b000);
    check("t1_level_e7", btn_level, 3'b111);
    check("t1_rise_cnt0", rise_cnt[0], 1);
    check("t1_rise_cnt2", rise_cnt[2], 1);

    // Return to a clean all-low state.
    rst_n = 1'b0; btn_raw = 3'b000;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    clear_counts();

    // 2. Clean press on ch0.
    btn_raw[0] = 1'b1;
    tick(6);
    check("t2_level_e5", btn_level, 3'b000);
    tick(1);
    check("t2_level_e6",  btn_level,  3'b001);
    check("t2_rise_e6",   btn_rise,   3'b001);
    check("t2_toggle_e6", btn_toggle, 3'b001);
    tick(1);
    check("t2_rise_e7", btn_rise, 3'b000);
    tick(3);
    check("t2_rise_cnt0", rise_cnt[0], 1);
    btn_raw[0] = 1'b0;
    tick(7);
    check("t2_rel_level", btn_level, 3'b000);
    check("t2_rel_fall",  btn_fall,  3'b001);
    tick(1);
    check("t2_rel_fall1", btn_fall, 3'b000);
    clear_counts();

    // 3. Bouncy press on ch1: 1,0,1,1,0 then held high.
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1;
    tick(6);
    check("t3_level_e5", btn_level, 3'b000);
    tick(1);
    check("t3_level_e6",  btn_level,  3'b010);
    check("t3_rise_e6",   btn_rise,   3'b010);
    check("t3_toggle_e6", btn_toggle, 3'b011);
    tick(2);
    check("t3_rise_cnt1", rise_cnt[1], 1);
    check("t3_fall_cnt1", fall_cnt[1], 0);
    btn_raw[1] = 1'b0;
    tick(8);
    check("t3_rel_level", btn_level, 3'b000);
    clear_counts();

    // 4. Short glitch on ch0 is rejected.
    btn_raw[0] = 1'b1; tick(3);
    btn_raw[0] = 1'b0; tick(10);
    check("t4_level",     btn_level,   3'b000);
    check("t4_rise_cnt0", rise_cnt[0], 0);
    check("t4_fall_cnt0", fall_cnt[0], 0);
    check("t4_toggle",    btn_toggle,  3'b011);
    clear_counts();

    // 5. Two press/release cycles on ch2.
    btn_raw[2] = 1'b1; tick(7);
    check("t5_p1_rise",   btn_rise,   3'b100);
    check("t5_p1_toggle", btn_toggle, 3'b111);
    tick(1);
    btn_raw[2] = 1'b0; tick(7);
    check("t5_r1_fall",  btn_fall,  3'b100);
    check("t5_r1_level", btn_level, 3'b000);
    tick(1);
    btn_raw[2] = 1'b1; tick(7);
    check("t5_p2_rise",   btn_rise,   3'b100);
    check("t5_p2_toggle", btn_toggle, 3'b011);
    tick(1);
    btn_raw[2] = 1'b0; tick(7);
    check("t5_r2_fall", btn_fall, 3'b100);
    tick(1);
    check("t5_fall_cnt2", fall_cnt[2], 2);
    check("t5_rise_cnt2", rise_cnt[2], 2);
    clear_counts();

    // 6. Reset in the middle of a debounce on ch1.
    btn_raw[1] = 1'b1; tick(2);
    rst_n = 1'b0; tick(1);
    check("t6_rst_level",  btn_level,  3'b000);
    check("t6_rst_toggle", btn_toggle, 3'b000);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("t6_level_e5", btn_level, 3'b000);
    tick(1);
    check("t6_level_e6", btn_level, 3'b010);
    check("t6_rise_e6",  btn_rise,  3'b010);
    tick(1);
    check("t6_rise_e7", btn_rise, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
